// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single RAM port.
// Data requests win contention unless the fetch side has been passed over
// for four consecutive data grants. Data requests may be bursts of up to
// 16 word beats, each beat separated by a single idle gap cycle. A RAM that
// does not answer within 16 cycles is abandoned and ERR is pulsed.
module mem_access_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_ACK,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [3:0]  D_CNT,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic        D_DONE,
  output logic [31:0] RDATA_Q,
  output logic        ERR,
  output logic        MOV,
  output logic        RW,
  output logic [2:0]  MS,
  output logic [31:0] ADDR,
  output logic [31:0] WDATA,
  input  logic        MOC,
  input  logic [31:0] RDATA
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, D_GAP} state_t;

  localparam logic [2:0] STARVE_MAX = 3'd4;
  localparam logic [3:0] TOUT_LAST  = 4'd15;
  localparam logic [2:0] FETCH_MS   = 3'b010;

  state_t      state_q, state_d;
  logic        mov_d, rw_d;
  logic [2:0]  ms_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic        if_ack_d, d_ack_d, d_done_d, err_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  tout_q, tout_d;
  logic [2:0]  starve_q, starve_d;

  // Next-state and next-value logic for every registered output and counter.
  always_comb begin
    state_d  = state_q;
    mov_d    = MOV;
    rw_d     = RW;
    ms_d     = MS;
    addr_d   = ADDR;
    wdata_d  = WDATA;
    rdata_d  = RDATA_Q;
    if_ack_d = 1'b0;
    d_ack_d  = 1'b0;
    d_done_d = 1'b0;
    err_d    = 1'b0;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    tout_d   = tout_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (D_REQ && !(IF_REQ && starve_q == STARVE_MAX)) begin
          state_d = D_ACC;
          mov_d   = 1'b1;
          rw_d    = D_RW;
          ms_d    = D_MS;
          addr_d  = D_ADDR;
          wdata_d = D_WDATA;
          beat_d  = '0;
          cnt_d   = D_CNT;
          tout_d  = '0;
          // Count only grants that made a pending fetch wait; saturates.
          if (IF_REQ && starve_q != STARVE_MAX)
            starve_d = starve_q + 3'd1;
        end else if (IF_REQ) begin
          state_d  = IF_ACC;
          mov_d    = 1'b1;
          rw_d     = 1'b1;
          ms_d     = FETCH_MS;
          addr_d   = IF_ADDR;
          tout_d   = '0;
          starve_d = '0;
        end
      end
      IF_ACC, D_ACC: begin
        if (MOC) begin
          mov_d  = 1'b0;
          tout_d = '0;
          if (RW)
            rdata_d = RDATA;
          if (state_q == IF_ACC) begin
            if_ack_d = 1'b1;
            state_d  = IDLE;
          end else begin
            d_ack_d = 1'b1;
            if (beat_q == cnt_q) begin
              d_done_d = 1'b1;
              state_d  = IDLE;
            end else begin
              beat_d  = beat_q + 4'd1;
              state_d = D_GAP;
            end
          end
        end else if (tout_q == TOUT_LAST) begin
          mov_d   = 1'b0;
          err_d   = 1'b1;
          tout_d  = '0;
          state_d = IDLE;
        end else begin
          tout_d = tout_q + 4'd1;
        end
      end
      D_GAP: begin
        // Next beat address is the previous one plus a word, wrapping at 2^32.
        state_d = D_ACC;
        mov_d   = 1'b1;
        addr_d  = ADDR + 32'd4;
        wdata_d = D_WDATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      MOV      <= 1'b0;
      RW       <= 1'b0;
      MS       <= '0;
      ADDR     <= '0;
      WDATA    <= '0;
      RDATA_Q  <= '0;
      IF_ACK   <= 1'b0;
      D_ACK    <= 1'b0;
      D_DONE   <= 1'b0;
      ERR      <= 1'b0;
      beat_q   <= '0;
      cnt_q    <= '0;
      tout_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      MOV      <= mov_d;
      RW       <= rw_d;
      MS       <= ms_d;
      ADDR     <= addr_d;
      WDATA    <= wdata_d;
      RDATA_Q  <= rdata_d;
      IF_ACK   <= if_ack_d;
      D_ACK    <= d_ack_d;
      D_DONE   <= d_done_d;
      ERR      <= err_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 The block SHALL use a single clock CLK: input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL provide reset RESET: input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL provide IF_REQ: input, 1 bit, instruction-fetch request, held until IF_ACK.
REQ-004 The block SHALL provide IF_ADDR: input, 32 bits, fetch word address.
REQ-005 The block SHALL provide IF_ACK: output, 1 bit, one-cycle pulse when fetch data is valid on RDATA_Q.
REQ-006 The block SHALL provide D_REQ: input, 1 bit, data request, held until D_DONE.
REQ-007 The block SHALL provide D_RW: input, 1 bit, 1 = read (load) and 0 = write (store).
REQ-008 The block SHALL provide D_MS: input, 3 bits, size code forwarded to RAM.
REQ-009 The block SHALL provide D_ADDR: input, 32 bits, first data address.
REQ-010 The block SHALL provide D_CNT: input, 4 bits, number of words minus 1, so 0 means a single access.
REQ-011 The block SHALL provide D_WDATA: input, 32 bits, store data for the current beat.
REQ-012 The block SHALL provide D_ACK: output, 1 bit, one-cycle pulse per completed beat.
REQ-013 The block SHALL provide D_DONE: output, 1 bit, one-cycle pulse coincident with the final D_ACK.
REQ-014 The block SHALL provide RDATA_Q: output, 32 bits, registered read data of the last read beat.
REQ-015 The block SHALL provide ERR: output, 1 bit, one-cycle pulse on timeout abort.
REQ-016 The block SHALL provide RAM-side signals: MOV output 1 bit; RW output 1 bit; MS output 3 bits; ADDR output 32 bits; WDATA output 32 bits; MOC input 1 bit; RDATA input 32 bits.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, IF_ACC, D_ACC, D_GAP.
REQ-018 In IDLE, a request sampled at edge k SHALL give MOV=1 in the cycle after edge k. ADDR, RW, MS and WDATA SHALL be registered at edge k and held constant while MOV=1.
REQ-019 A fetch SHALL drive RW=1 and MS=3'b010.
REQ-020 A data access SHALL drive RW=D_RW and MS=D_MS.
REQ-021 Arbitration: when IF_REQ and D_REQ are both high in IDLE, the data request SHALL win, unless 4 consecutive data transactions have been granted while IF_REQ was pending, in which case fetch SHALL win. The starvation counter SHALL clear on any fetch grant.
REQ-022 When MOC=1 is sampled in an ACC state, the block SHALL set MOV=0 on the next cycle, latch RDATA into RDATA_Q on reads, and pulse IF_ACK or D_ACK in the cycle after that edge. Minimum request-to-ACK latency SHALL therefore be 2 cycles.
REQ-023 Burst transfers: beat i SHALL use ADDR = D_ADDR + 4*i (32-bit wrap-around, no carry-out).
REQ-024 After each non-final beat, the FSM SHALL enter D_GAP for exactly one cycle with MOV=0, then re-enter D_ACC. D_WDATA SHALL be sampled on the D_GAP edge.
REQ-025 After beat D_CNT, D_DONE SHALL pulse with D_ACK and the FSM SHALL return to IDLE. A burst SHALL never be interrupted by IF_REQ.
REQ-026 Timeout: if MOC stays 0 for 16 consecutive cycles with MOV=1, the block SHALL set MOV=0, pulse ERR, and return to IDLE.
REQ-027 On timeout, no ACK SHALL be issued, and D_DONE SHALL NOT be pulsed for an aborted burst.
REQ-028 MOC sampled while MOV=0 SHALL be ignored.
REQ-029 A requester dropping REQ mid-access SHALL NOT abort the access. The ACK SHALL still pulse.
REQ-030 IF_ACK and D_ACK SHALL never be high in the same cycle.

Reset
REQ-031 With RESET=1 at a rising edge: state SHALL be IDLE; MOV, RW, IF_ACK, D_ACK, D_DONE and ERR SHALL be 0; MS=3'b000; ADDR, WDATA and RDATA_Q SHALL be 32'd0; the beat and timeout counters SHALL be 0; the starvation counter SHALL be 0.
REQ-032 RESET SHALL have priority over all other inputs. A reset mid-access or mid-burst SHALL abort without any ACK, DONE or ERR.

Verification
REQ-033 Fetch: IF_REQ=1, IF_ADDR=0x10, MOC=1 one cycle after MOV rises, RDATA=0xE0800001 -> RW=1, MS=010, ADDR=0x10, IF_ACK at cycle 3, RDATA_Q=0xE0800001.
REQ-034 Contention: IF_REQ and D_REQ both high at the same edge (D_RW=0, D_ADDR=0x20) -> the data write is served first, with WDATA=D_WDATA, followed by the fetch; IF_ACK and D_ACK are never simultaneous.
REQ-035 Burst: D_CNT=3, D_ADDR=0xFFFFFFF8, read -> ADDR sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 with one MOV=0 gap cycle between beats, 4 D_ACK pulses, and D_DONE only on the 4th.
REQ-036 Starvation: IF_REQ held while 5 single data requests arrive back-to-back -> the fetch is granted after the 4th data transaction.
REQ-037 Timeout: MOC held 0 -> MOV drops after 16 cycles high, ERR pulses once, no ACK, and state returns to IDLE.
REQ-038 Reset during beat 2 of a burst -> all outputs match REQ-031 at the next edge, no D_DONE is issued, and a new IF_REQ is served normally afterward.
